// File: rtl/keccak_squeeze_serializer.sv
// rtl/keccak_squeeze_serializer.sv - streams the Keccak rate lanes as an MSB-first byte stream
// Tracks the requested output length across blocks, requesting permutations and masking the tail.
module keccak_squeeze_serializer #(
   parameter int LANE_W     = 64,
   parameter int RATE_LANES = 17,
   parameter int OUT_W      = 64,
   parameter int LEN_W      = 16
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              start,
   input  logic [LEN_W-1:0]                  len_bytes,
   input  logic [0:4][0:4][LANE_W-1:0]       state_in,
   input  logic                              state_valid,
   output logic                              state_ready,
   output logic                              perm_req,
   output logic [OUT_W-1:0]                  out_data,
   output logic [OUT_W/8-1:0]                out_keep,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic                              out_last,
   output logic                              busy,
   output logic                              done
);

   localparam int LB    = LANE_W / 8;
   localparam int NB    = OUT_W / 8;
   localparam int TOT_W = RATE_LANES * LANE_W;
   localparam int BPB   = TOT_W / OUT_W;
   localparam int BI_W  = (BPB > 1) ? $clog2(BPB) : 1;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_STREAM, S_REQ} state_t;

   state_t            st;
   logic [LEN_W-1:0]  remaining;
   logic [BI_W-1:0]   beat_idx;
   logic [TOT_W-1:0]  stream;
   logic [TOT_W-1:0]  cap_stream;
   logic              unused_capacity;

   // Capacity lanes are never streamed; fold them away so they are visibly ignored.
   assign unused_capacity = ^state_in;

   // Lane i = x + 5y, little-endian within the lane, byte 0 of the block at the MSB end.
   always_comb begin
      cap_stream = '0;
      for (int i = 0; i < RATE_LANES; i++) begin
         for (int b = 0; b < LB; b++) begin
            cap_stream[TOT_W-1-8*(i*LB+b) -: 8] = state_in[i%5][i/5][8*b +: 8];
         end
      end
   end

   // The head of the shift register is always the current beat; bytes past the length read as 0.
   always_comb begin
      out_data = '0;
      out_keep = '0;
      for (int j = 0; j < NB; j++) begin
         if (out_valid && (LEN_W'(j) < remaining)) begin
            out_keep[NB-1-j]        = 1'b1;
            out_data[8*(NB-1-j) +: 8] = stream[TOT_W-1-8*j -: 8];
         end
      end
   end

   assign out_last = out_valid && (remaining <= LEN_W'(NB));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st          <= S_IDLE;
         remaining   <= '0;
         beat_idx    <= '0;
         stream      <= '0;
         state_ready <= 1'b0;
         perm_req    <= 1'b0;
         out_valid   <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         done     <= 1'b0;
         perm_req <= 1'b0;
         case (st)
            S_IDLE: begin
               if (start) begin
                  if (len_bytes == '0) begin
                     done <= 1'b1;
                  end else begin
                     remaining   <= len_bytes;
                     st          <= S_WAIT;
                     state_ready <= 1'b1;
                     busy        <= 1'b1;
                  end
               end
            end
            S_WAIT: begin
               if (state_valid) begin
                  stream      <= cap_stream;
                  beat_idx    <= '0;
                  st          <= S_STREAM;
                  state_ready <= 1'b0;
                  out_valid   <= 1'b1;
               end
            end
            S_STREAM: begin
               if (out_ready) begin
                  // Length exhaustion wins over the block boundary so no spare permutation is asked for.
                  if (remaining <= LEN_W'(NB)) begin
                     remaining <= '0;
                     out_valid <= 1'b0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     st        <= S_IDLE;
                  end else begin
                     remaining <= remaining - LEN_W'(NB);
                     stream    <= stream << OUT_W;
                     if (beat_idx == BI_W'(BPB-1)) begin
                        out_valid <= 1'b0;
                        perm_req  <= 1'b1;
                        st        <= S_REQ;
                     end else begin
                        beat_idx <= beat_idx + 1'b1;
                     end
                  end
               end
            end
            S_REQ: begin
               st          <= S_WAIT;
               state_ready <= 1'b1;
            end
            default: st <= S_IDLE;
         endcase
      end
   end

endmodule
